// File: rtl/q_max_fetch_pkg.sv
// Shared Q-learning datapath constants and the fetch FSM state encoding.
package q_pkg;

    localparam int STATE_W   = 4;
    localparam int ACT_W     = 2;
    localparam int Q_W       = 16;
    localparam int N_ACTIONS = 1 << ACT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/q_max_fetch_cmp.sv
// Signed strict-greater compare between the running max and a new Q-value.
// Ties keep the incumbent, so the lower action index wins.
module q_max_cmp #(
    parameter int Q_W   = 16,
    parameter int ACT_W = 2
) (
    input  logic [Q_W-1:0]   cur_val,
    input  logic [ACT_W-1:0] cur_idx,
    input  logic [Q_W-1:0]   new_val,
    input  logic [ACT_W-1:0] new_idx,
    output logic [Q_W-1:0]   sel_val,
    output logic [ACT_W-1:0] sel_idx
);

    // Pick the new candidate only when it is strictly larger as a signed value.
    always_comb begin
        sel_val = cur_val;
        sel_idx = cur_idx;
        if ($signed(new_val) > $signed(cur_val)) begin
            sel_val = new_val;
            sel_idx = new_idx;
        end
    end

endmodule

// File: rtl/q_max_fetch.sv
// Fetches Q(s,a) and max/argmax over a' of Q(s',a') from the Q-table RAM
// for one transition, presenting registered results with a valid pulse.
module q_max_fetch
    import q_pkg::*;
#(
    parameter int STATE_W = q_pkg::STATE_W,
    parameter int ACT_W   = q_pkg::ACT_W,
    parameter int Q_W     = q_pkg::Q_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [STATE_W-1:0]       cur_state,
    input  logic [ACT_W-1:0]         cur_action,
    input  logic [STATE_W-1:0]       next_state,
    output logic [STATE_W+ACT_W-1:0] ram_addr,
    output logic                     ram_rd_en,
    input  logic [Q_W-1:0]           ram_rd_data,
    output logic [Q_W-1:0]           old_Q,
    output logic [Q_W-1:0]           max_Q,
    output logic [ACT_W-1:0]         max_action,
    output logic                     busy,
    output logic                     valid
);

    localparam int IDX_W  = ACT_W + 1;
    localparam int ADDR_W = STATE_W + ACT_W;
    localparam int N_ACT  = 1 << ACT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACT);

    fetch_state_e state_q, state_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [STATE_W-1:0] s_q, s_d, sp_q, sp_d;
    logic [ACT_W-1:0]   a_q, a_d;
    logic               cap_vld_q, cap_vld_d;
    logic [IDX_W-1:0]   cap_idx_q, cap_idx_d;
    logic [Q_W-1:0]     old_val_q, old_val_d;
    logic [Q_W-1:0]     max_val_q, max_val_d;
    logic [ACT_W-1:0]   max_act_q, max_act_d;
    logic               ram_rd_en_q, ram_rd_en_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic [IDX_W-1:0]   next_act_full;
    logic [IDX_W-1:0]   cap_act_full;
    logic [Q_W-1:0]     cmp_val;
    logic [ACT_W-1:0]   cmp_idx;

    // Read index k>=1 addresses action k-1 of s'; same offset for returned data.
    assign next_act_full = rd_idx_d - IDX_W'(1);
    assign cap_act_full  = cap_idx_q - IDX_W'(1);

    q_max_cmp #(
        .Q_W   (Q_W),
        .ACT_W (ACT_W)
    ) u_cmp (
        .cur_val (max_val_q),
        .cur_idx (max_act_q),
        .new_val (ram_rd_data),
        .new_idx (cap_act_full[ACT_W-1:0]),
        .sel_val (cmp_val),
        .sel_idx (cmp_idx)
    );

    // Next-state logic plus next values of the registered RAM strobe/address and status.
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        s_d         = s_q;
        a_d         = a_q;
        sp_d        = sp_q;
        ram_rd_en_d = 1'b0;
        ram_addr_d  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d      = cur_state;
                    a_d      = cur_action;
                    sp_d     = next_state;
                    rd_idx_d = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                if (rd_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == READ) begin
            ram_rd_en_d = 1'b1;
            if (rd_idx_d == '0) begin
                ram_addr_d = {s_d, a_d};
            end else begin
                ram_addr_d = {sp_d, next_act_full[ACT_W-1:0]};
            end
        end
        busy_d    = (state_d == READ) || (state_d == DRAIN);
        valid_d   = (state_d == DONE);
        cap_vld_d = ram_rd_en_q;
        cap_idx_d = rd_idx_q;
    end

    // Capture each read return one cycle after its strobe into old_Q or the running max.
    always_comb begin
        old_val_d = old_val_q;
        max_val_d = max_val_q;
        max_act_d = max_act_q;
        if (cap_vld_q) begin
            if (cap_idx_q == '0) begin
                old_val_d = ram_rd_data;
            end else if (cap_idx_q == IDX_W'(1)) begin
                max_val_d = ram_rd_data;
                max_act_d = '0;
            end else begin
                max_val_d = cmp_val;
                max_act_d = cmp_idx;
            end
        end
    end

    // All state and outputs registered; reset also drops any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_idx_q    <= '0;
            s_q         <= '0;
            a_q         <= '0;
            sp_q        <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            old_val_q   <= '0;
            max_val_q   <= '0;
            max_act_q   <= '0;
            ram_rd_en_q <= 1'b0;
            ram_addr_q  <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            s_q         <= s_d;
            a_q         <= a_d;
            sp_q        <= sp_d;
            cap_vld_q   <= cap_vld_d;
            cap_idx_q   <= cap_idx_d;
            old_val_q   <= old_val_d;
            max_val_q   <= max_val_d;
            max_act_q   <= max_act_d;
            ram_rd_en_q <= ram_rd_en_d;
            ram_addr_q  <= ram_addr_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_rd_en  = ram_rd_en_q;
    assign old_Q      = old_val_q;
    assign max_Q      = max_val_q;
    assign max_action = max_act_q;
    assign busy       = busy_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_q_max_fetch.sv
// Directed self-checking bench for q_max_fetch with a one-cycle-latency RAM model.
module tb_q_max_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cur_state;
    logic [1:0]  cur_action;
    logic [3:0]  next_state;
    logic [5:0]  ram_addr;
    logic        ram_rd_en;
    logic [15:0] ram_rd_data;
    logic [15:0] old_Q;
    logic [15:0] max_Q;
    logic [1:0]  max_action;
    logic        busy;
    logic        valid;

    logic [15:0] mem [64];
    logic [5:0]  addr_log [$];
    int          checks;
    int          errors;

    q_max_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cur_state   (cur_state),
        .cur_action  (cur_action),
        .next_state  (next_state),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_data (ram_rd_data),
        .old_Q       (old_Q),
        .max_Q       (max_Q),
        .max_action  (max_action),
        .busy        (busy),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model that also logs every issued address.
    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_data <= mem[ram_addr];
            addr_log.push_back(ram_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAddrSeq(input int base, input logic [3:0] s, input logic [1:0] a, input logic [3:0] sp);
        logic [5:0]  exp_addr [5];
        logic [31:0] obs;
        exp_addr[0] = {s, a};
        for (int k = 0; k < 4; k++) exp_addr[k+1] = {sp, 2'(k)};
        for (int k = 0; k < 5; k++) begin
            obs = (addr_log.size() > base + k) ? 32'(addr_log[base + k]) : 32'hFFFF_FFFF;
            checkOutput($sformatf("addr[%0d]", base + k), obs, 32'(exp_addr[k]));
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] e_old, input logic [15:0] e_max, input logic [1:0] e_act);
        checkOutput({tag, "_old_Q"}, 32'(old_Q), 32'(e_old));
        checkOutput({tag, "_max_Q"}, 32'(max_Q), 32'(e_max));
        checkOutput({tag, "_max_action"}, 32'(max_action), 32'(e_act));
    endtask

    // Launches one fetch from a falling edge and walks to the valid cycle (6 edges later).
    task automatic applyStimulus(input logic [3:0] s, input logic [1:0] a, input logic [3:0] sp, input bit hold);
        int busy_cnt;
        int early_valid;
        busy_cnt    = 0;
        early_valid = 0;
        addr_log.delete();
        cur_state  = s;
        cur_action = a;
        next_state = sp;
        start      = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy)  busy_cnt++;
            if (valid) early_valid++;
            @(negedge clk);
        end
        checkOutput("valid_at_latency", 32'(valid), 32'd1);
        checkOutput("busy_in_done", 32'(busy), 32'd0);
        checkOutput("busy_cycles", 32'(busy_cnt), 32'd6);
        checkOutput("early_valid", 32'(early_valid), 32'd0);
        checkOutput("rd_en_in_done", 32'(ram_rd_en), 32'd0);
        checkOutput("addr_in_done", 32'(ram_addr), 32'd0);
        checkOutput("read_count", 32'(addr_log.size()), 32'd5);
        checkAddrSeq(0, s, a, sp);
    endtask

    initial begin
        int vcount;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        cur_state  = '0;
        cur_action = '0;
        next_state = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        // Q(3,*) = {10,-5,40,7}, Q(2,1) = 100
        mem[12] = 16'd10;   mem[13] = 16'hFFFB; mem[14] = 16'd40;   mem[15] = 16'd7;
        mem[9]  = 16'd100;
        // Q(5,*) = {-3,-3,-9,-3}, Q(4,2) = 0x1234
        mem[20] = 16'hFFFD; mem[21] = 16'hFFFD; mem[22] = 16'hFFF7; mem[23] = 16'hFFFD;
        mem[18] = 16'h1234;
        // Q(1,*) = {8000,8000,7FFF,0}
        mem[4]  = 16'h8000; mem[5]  = 16'h8000; mem[6]  = 16'h7FFF; mem[7]  = 16'h0000;
        // Q(7,*) = {1,2,-7,50}
        mem[28] = 16'd1;    mem[29] = 16'd2;    mem[30] = 16'hFFF9; mem[31] = 16'd50;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_rd_en", 32'(ram_rd_en), 32'd0);
        checkResult("reset", 16'h0, 16'h0, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: basic fetch");
        applyStimulus(4'd2, 2'd1, 4'd3, 1'b0);
        checkResult("t1", 16'd100, 16'd40, 2'd2);
        @(negedge clk);
        checkOutput("t1_valid_one_cycle", 32'(valid), 32'd0);
        repeat (3) @(negedge clk);
        checkResult("t1_hold", 16'd100, 16'd40, 2'd2);

        $display("[TB] test 2/4: ties on negatives with start held high");
        applyStimulus(4'd4, 2'd2, 4'd5, 1'b1);
        checkResult("t2", 16'h1234, 16'hFFFD, 2'd0);
        @(negedge clk);
        checkOutput("t4_idle_after_done", 32'(busy), 32'd0);
        checkOutput("t4_valid_drop", 32'(valid), 32'd0);
        @(negedge clk);
        checkOutput("t4_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("t4_second_valid", 32'(valid), 32'd1);
        checkOutput("t4_total_reads", 32'(addr_log.size()), 32'd10);
        checkAddrSeq(5, 4'd4, 2'd2, 4'd5);
        checkResult("t4", 16'h1234, 16'hFFFD, 2'd0);
        @(negedge clk);

        $display("[TB] test 3: most negative / most positive boundaries");
        applyStimulus(4'd0, 2'd0, 4'd1, 1'b0);
        checkResult("t3", 16'h0000, 16'h7FFF, 2'd2);
        @(negedge clk);

        $display("[TB] test 5: reset during READ");
        cur_state  = 4'd2;
        cur_action = 2'd1;
        next_state = 4'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_valid", 32'(valid), 32'd0);
        checkOutput("t5_rd_en", 32'(ram_rd_en), 32'd0);
        checkOutput("t5_addr", 32'(ram_addr), 32'd0);
        checkResult("t5", 16'h0, 16'h0, 2'd0);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid || busy) vcount++;
            @(negedge clk);
        end
        checkOutput("t5_no_activity", 32'(vcount), 32'd0);

        $display("[TB] test 6: s equals s', unique max at last action");
        applyStimulus(4'd7, 2'd3, 4'd7, 1'b0);
        checkResult("t6", 16'd50, 16'd50, 2'd3);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
